cla_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one cla32 adder among NREQ requesters.

---
 rtl/cla_rr_sched.sv | 166 ++++++++++++++++
 tb/tb_cla_rr_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_rr_sched.sv
// Round-robin scheduler that time-shares one 32-bit carry-lookahead adder among NREQ requesters.
// Two-stage pipeline (operands -> sum) with a single backpressured response port tagged by requester id.

module cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [32:0] o_sum
);
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [31:0] w_c;
    logic [7:0]  w_gg;
    logic [7:0]  w_gp;
    logic [8:0]  w_gc;

    // 4-bit lookahead groups; group carries chained through group generate/propagate
    always_comb begin
        w_p  = i_a ^ i_b;
        w_g  = i_a & i_b;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        for (int j = 0; j < 8; j++) begin
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_gp[j] = &w_p[4*j +: 4];
        end
        for (int j = 0; j < 8; j++) begin
            w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
        end
        for (int j = 0; j < 8; j++) begin
            w_c[4*j]   = w_gc[j];
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
            w_c[4*j+2] = w_g[4*j+1]
                       | (w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
            w_c[4*j+3] = w_g[4*j+2]
                       | (w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
        end
        o_sum = {w_gc[8], w_p ^ w_c};
    end
endmodule

module cla_rr_sched #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [32:0]          rsp_sum,
    output logic [1:0]           inflight
);
    logic [IDW-1:0]  r_rr_ptr;

    logic [31:0]     r_a_p1;
    logic [31:0]     r_b_p1;
    logic [IDW-1:0]  r_id_p1;
    logic            r_vld_p1;

    logic [32:0]     r_sum_p2;
    logic [IDW-1:0]  r_id_p2;
    logic            r_vld_p2;

    logic            w_adv1;
    logic            w_adv2;
    logic [NREQ-1:0] w_mask_hi;
    logic [NREQ-1:0] w_req_hi;
    logic [IDW-1:0]  w_winner;
    logic            w_found;
    logic            w_grant;
    logic [NREQ-1:0] w_onehot;
    logic [31:0]     w_a_sel;
    logic [31:0]     w_b_sel;
    logic [32:0]     w_sum;

    assign w_adv2 = !r_vld_p2 | rsp_ready;
    assign w_adv1 = !r_vld_p1 | w_adv2;

    // Requests above the last grant win first; otherwise wrap to the lowest index.
    always_comb begin
        w_mask_hi = '0;
        w_winner  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask_hi[i] = (IDW'(i) > r_rr_ptr);
        end
        w_req_hi = req_valid & w_mask_hi;
        w_found  = |req_valid;
        if (|w_req_hi) begin
            for (int i = NREQ-1; i >= 0; i--) begin
                if (w_req_hi[i]) w_winner = IDW'(i);
            end
        end else begin
            for (int i = NREQ-1; i >= 0; i--) begin
                if (req_valid[i]) w_winner = IDW'(i);
            end
        end
    end

    assign w_grant = w_found & w_adv1 & !rst;

    always_comb begin
        w_onehot = '0;
        w_a_sel  = '0;
        w_b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_onehot[i] = 1'b1;
                w_a_sel     = req_a[32*i +: 32];
                w_b_sel     = req_b[32*i +: 32];
            end
        end
    end

    assign req_ready = w_grant ? w_onehot : '0;

    cla32 u_cla32 (
        .i_a   (r_a_p1),
        .i_b   (r_b_p1),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= IDW'(NREQ-1);
            r_a_p1   <= '0;
            r_b_p1   <= '0;
            r_id_p1  <= '0;
            r_vld_p1 <= 1'b0;
            r_sum_p2 <= '0;
            r_id_p2  <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            // Stage 1: operand capture from the arbitration winner (bubble when no grant)
            if (w_adv1) begin
                r_a_p1   <= w_a_sel;
                r_b_p1   <= w_b_sel;
                r_id_p1  <= w_winner;
                r_vld_p1 <= w_grant;
            end
            if (w_grant) r_rr_ptr <= w_winner;
            // Stage 2: adder result register driving the response port
            if (w_adv2) begin
                r_sum_p2 <= w_sum;
                r_id_p2  <= r_id_p1;
                r_vld_p2 <= r_vld_p1;
            end
        end
    end

    assign rsp_valid = r_vld_p2;
    assign rsp_id    = r_id_p2;
    assign rsp_sum   = r_sum_p2;
    assign inflight  = {1'b0, r_vld_p1} + {1'b0, r_vld_p2};
endmodule

// File: tb/tb_cla_rr_sched.sv
// Directed bench for cla_rr_sched: table of single adds plus hand sequences for
// reset, fairness, backpressure and mid-flight reset.

module tb_cla_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [32:0]         rsp_sum;
    logic [1:0]          inflight;

    int n_chk;
    int n_fail;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] sum;
    } vec_t;

    vec_t vecs [8];

    cla_rr_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [32:0] t3_sum(input int id);
        return 33'(256 * (id + 1) + id);
    endfunction

    function automatic logic [32:0] t4_sum(input int id);
        return 33'(32'h1000 + id + 32'h10 * id);
    endfunction

    initial begin
        logic [NREQ-1:0] oh;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{0, 32'h0000_0005, 32'h0000_0003, 33'h0_0000_0008};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
        vecs[2] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
        vecs[3] = '{3, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
        vecs[4] = '{0, 32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999};
        vecs[5] = '{1, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
        vecs[6] = '{3, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 33'h0_FFFF_FFFF};
        vecs[7] = '{2, 32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000};

        // T1: reset held two cycles with every requester asking
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("rst_req_ready", req_ready, '0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_inflight", inflight, 0);
        end
        rst       = 1'b0;
        req_valid = '0;

        // T2/T5: table of isolated adds, one requester at a time
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            oh        = 4'b0001 << vecs[v].id;
            req_valid = oh;
            set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
            #1;
            chk("vec_req_ready", req_ready, oh);
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("vec_inflight_s1", inflight, 1);
            chk("vec_rsp_early", rsp_valid, 0);
            @(negedge clk);
            #1;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_id", rsp_id, vecs[v].id);
            chk("vec_rsp_sum", rsp_sum, vecs[v].sum);
            @(negedge clk);
            #1;
            chk("vec_rsp_done", rsp_valid, 0);
            chk("vec_inflight_end", inflight, 0);
        end

        // T3: fairness with all requesters held valid, rr_ptr freshly reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'h100 * (i + 1), i);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 6) req_valid = '0;
            #1;
            if (c < 6) chk("rr_grant", req_ready, 4'b0001 << (c % 4));
            else       chk("rr_no_grant", req_ready, 0);
            if (c >= 2) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_id", rsp_id, (c - 2) % 4);
                chk("rr_rsp_sum", rsp_sum, t3_sum((c - 2) % 4));
            end
        end
        @(negedge clk);
        #1;
        chk("rr_drained_valid", rsp_valid, 0);
        chk("rr_drained_inflight", inflight, 0);

        // T4: backpressure with three pending requests
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'h1000 + i, 32'h10 * i);
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        #1;
        chk("bp_grant0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0110;
        #1;
        chk("bp_grant1", req_ready, 4'b0010);
        chk("bp_inflight1", inflight, 1);
        chk("bp_rsp_idle", rsp_valid, 0);
        @(negedge clk);
        req_valid = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("bp_full_ready", req_ready, 0);
            chk("bp_full_inflight", inflight, 2);
            chk("bp_full_valid", rsp_valid, 1);
            chk("bp_full_id", rsp_id, 0);
            chk("bp_full_sum", rsp_sum, t4_sum(0));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", req_ready, 4'b0100);
        chk("bp_rsp0_id", rsp_id, 0);
        chk("bp_rsp0_sum", rsp_sum, t4_sum(0));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("bp_rsp1_valid", rsp_valid, 1);
        chk("bp_rsp1_id", rsp_id, 1);
        chk("bp_rsp1_sum", rsp_sum, t4_sum(1));
        chk("bp_inflight_a", inflight, 2);
        @(negedge clk);
        #1;
        chk("bp_rsp2_valid", rsp_valid, 1);
        chk("bp_rsp2_id", rsp_id, 2);
        chk("bp_rsp2_sum", rsp_sum, t4_sum(2));
        chk("bp_inflight_b", inflight, 1);
        @(negedge clk);
        #1;
        chk("bp_done_valid", rsp_valid, 0);
        chk("bp_done_inflight", inflight, 0);

        // T6: reset while two adds are in flight
        rsp_ready = 1'b0;
        set_ops(3, 32'hDEAD_0000, 32'h0000_BEEF);
        req_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_inflight_full", inflight, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_inflight", inflight, 0);
        chk("mid_rsp_sum", rsp_sum, 0);
        chk("mid_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_final_inflight", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
